// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forwarding-select encodings,
// the scoreboard entry type and the source/entry match rule.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef struct packed {
      logic       valid;
      logic [4:0] addr;
      logic       regwrite;
      logic       load;
   } sb_entry_t;

   // Register 0 is hardwired, so it can never be a real dependency.
   function automatic logic entry_hit(sb_entry_t e, logic [4:0] src, logic src_used);
      return e.valid && e.regwrite && (e.addr == src) && (src != 5'd0) && src_used;
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one decode source against the EX/MEM/WB scoreboard entries.
// HAZARD_FORWARD_EN selects forwarding; otherwise any match is a stall.
module hazard_cmp
   import hazard_pkg::*;
(
   input  logic [4:0] src,
   input  logic       src_used,
   input  sb_entry_t  ex_entry,
   input  sb_entry_t  mem_entry,
   input  sb_entry_t  wb_entry,
   output logic [1:0] sel,
   output logic       stall_hit
);

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;
   logic unused_load_bits;

   assign ex_hit  = entry_hit(ex_entry,  src, src_used);
   assign mem_hit = entry_hit(mem_entry, src, src_used);
   assign wb_hit  = entry_hit(wb_entry,  src, src_used);

`ifdef HAZARD_FORWARD_EN
   // Youngest producer wins; a load still in EX has no data yet.
   always_comb begin
      sel = FWD_RF;
      if (ex_hit) begin
         sel = ex_entry.load ? FWD_RF : FWD_EX;
      end else if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
   end

   assign stall_hit        = ex_hit & ex_entry.load;
   assign unused_load_bits = mem_entry.load ^ wb_entry.load;
`else
   assign sel              = FWD_RF;
   assign stall_hit        = ex_hit | mem_hit | wb_hit;
   assign unused_load_bits = ex_entry.load ^ mem_entry.load ^ wb_entry.load;
`endif

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: three-entry scoreboard, per-operand forwarding
// selects, load-use stall/bubble and a saturating stall counter (HAZARD_FORWARD_EN).
module hazard_unit
   import hazard_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_id_rs,
   input  logic [4:0]  i_id_rt,
   input  logic        i_id_use_rs,
   input  logic        i_id_use_rt,
   input  logic [4:0]  i_id_wr_addr,
   input  logic        i_id_regwrite,
   input  logic        i_id_load,
   input  logic        i_id_valid,
   input  logic        i_flush,
   output logic [1:0]  o_mux_ctrl1,
   output logic [1:0]  o_mux_ctrl2,
   output logic        o_stall,
   output logic        o_bubble,
   output logic [15:0] o_stall_cnt
);

   sb_entry_t   ex_reg;
   sb_entry_t   mem_reg;
   sb_entry_t   wb_reg;
   sb_entry_t   id_entry;
   logic [15:0] stall_cnt_reg;
   logic [1:0]  sel_rs;
   logic [1:0]  sel_rt;
   logic        stall_hit_rs;
   logic        stall_hit_rt;
   logic        hazard;

   hazard_cmp u_cmp_rs (
      .src       (i_id_rs),
      .src_used  (i_id_use_rs),
      .ex_entry  (ex_reg),
      .mem_entry (mem_reg),
      .wb_entry  (wb_reg),
      .sel       (sel_rs),
      .stall_hit (stall_hit_rs)
   );

   hazard_cmp u_cmp_rt (
      .src       (i_id_rt),
      .src_used  (i_id_use_rt),
      .ex_entry  (ex_reg),
      .mem_entry (mem_reg),
      .wb_entry  (wb_reg),
      .sel       (sel_rt),
      .stall_hit (stall_hit_rt)
   );

   // A flushed instruction is discarded anyway, so flush overrides the stall.
   assign hazard      = stall_hit_rs | stall_hit_rt;
   assign o_stall     = hazard & ~i_flush;
   assign o_bubble    = hazard | i_flush;
   assign o_mux_ctrl1 = o_stall ? FWD_RF : sel_rs;
   assign o_mux_ctrl2 = o_stall ? FWD_RF : sel_rt;
   assign o_stall_cnt = stall_cnt_reg;

   assign id_entry = '{valid:    1'b1,
                       addr:     i_id_wr_addr,
                       regwrite: i_id_regwrite,
                       load:     i_id_load};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_reg        <= '0;
         mem_reg       <= '0;
         wb_reg        <= '0;
         stall_cnt_reg <= '0;
      end else begin
         wb_reg  <= mem_reg;
         mem_reg <= ex_reg;
         ex_reg  <= (i_id_valid && !o_stall && !i_flush) ? id_entry : '0;
         if (o_stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// traffic against a history-based reference model (HAZARD_FORWARD_EN aware).
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, id_wr_addr;
   logic        id_use_rs, id_use_rt, id_regwrite, id_load, id_valid, flush;
   logic [1:0]  mux_ctrl1, mux_ctrl2;
   logic        stall, bubble;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference history: index 0 = most recently issued (EX), 2 = oldest (WB).
   bit          mv[3];
   bit [4:0]    ma[3];
   bit          mw[3];
   bit          ml[3];
   int unsigned mcnt;

   logic [1:0]  obs_m1, obs_m2;
   logic        obs_st, obs_bb;

   always #5 clk = ~clk;

   hazard_unit dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_id_rs       (id_rs),
      .i_id_rt       (id_rt),
      .i_id_use_rs   (id_use_rs),
      .i_id_use_rt   (id_use_rt),
      .i_id_wr_addr  (id_wr_addr),
      .i_id_regwrite (id_regwrite),
      .i_id_load     (id_load),
      .i_id_valid    (id_valid),
      .i_flush       (flush),
      .o_mux_ctrl1   (mux_ctrl1),
      .o_mux_ctrl2   (mux_ctrl2),
      .o_stall       (stall),
      .o_bubble      (bubble),
      .o_stall_cnt   (stall_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int youngest(bit [4:0] src, bit used);
      for (int k = 0; k < 3; k++) begin
         if (used && src != 5'd0 && mv[k] && mw[k] && ma[k] == src) return k;
      end
      return -1;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 3; k++) begin
         mv[k] = 0; ma[k] = 0; mw[k] = 0; ml[k] = 0;
      end
      mcnt = 0;
   endfunction

   task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] wa,
                       input logic rw, input logic ld, input logic vld, input logic fl);
      int         a1, a2;
      bit         raw, est, ebb;
      logic [1:0] em1, em2;
      @(negedge clk);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_wr_addr = wa; id_regwrite = rw; id_load = ld; id_valid = vld; flush = fl;
      #1;
      a1 = youngest(rs, urs);
      a2 = youngest(rt, urt);
`ifdef HAZARD_FORWARD_EN
      raw = (a1 == 0 && ml[0]) || (a2 == 0 && ml[0]);
      em1 = (a1 < 0) ? 2'd0 : 2'(a1 + 1);
      em2 = (a2 < 0) ? 2'd0 : 2'(a2 + 1);
`else
      raw = (a1 >= 0) || (a2 >= 0);
      em1 = 2'd0;
      em2 = 2'd0;
`endif
      est = raw && !fl;
      ebb = raw || fl;
      if (est) begin
         em1 = 2'd0;
         em2 = 2'd0;
      end
      obs_m1 = mux_ctrl1; obs_m2 = mux_ctrl2; obs_st = stall; obs_bb = bubble;
      if (!fl) begin
         check({tag, ".mux1"}, 16'(mux_ctrl1), 16'(em1));
         check({tag, ".mux2"}, 16'(mux_ctrl2), 16'(em2));
      end
      check({tag, ".stall"},  16'(stall),  16'(est));
      check({tag, ".bubble"}, 16'(bubble), 16'(ebb));
      check({tag, ".cnt"},    stall_cnt,   16'(mcnt));
      $display("step %-10s rs=%0d rt=%0d wa=%0d v=%0b fl=%0b -> m1=%0d m2=%0d st=%0b bb=%0b cnt=%0d",
               tag, rs, rt, wa, vld, fl, mux_ctrl1, mux_ctrl2, stall, bubble, stall_cnt);
      @(posedge clk);
      for (int k = 2; k > 0; k--) begin
         mv[k] = mv[k-1]; ma[k] = ma[k-1]; mw[k] = mw[k-1]; ml[k] = ml[k-1];
      end
      mv[0] = vld && !est && !fl;
      ma[0] = wa; mw[0] = rw; ml[0] = ld;
      if (est && mcnt != 32'hFFFF) mcnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int          nst;
      logic [15:0] cnt0;
      model_clear();
      rst_n = 1'b0;
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      id_wr_addr = 0; id_regwrite = 0; id_load = 0; id_valid = 0; flush = 0;
      #1;
      check("rst.mux1",   16'(mux_ctrl1), 16'd0);
      check("rst.mux2",   16'(mux_ctrl2), 16'd0);
      check("rst.stall",  16'(stall),     16'd0);
      check("rst.bubble", 16'(bubble),    16'd0);
      check("rst.cnt",    stall_cnt,      16'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // add $3 then beq $3,$4
      step("add3", 0, 0, 0, 0, 3, 1, 0, 1, 0);
      step("beq34", 3, 4, 1, 1, 0, 0, 0, 1, 0);
`ifdef HAZARD_FORWARD_EN
      check("ex_fwd.sel", 16'(obs_m1), 16'd1);
      check("ex_fwd.stall", 16'(obs_st), 16'd0);
`else
      check("ex_fwd.stall", 16'(obs_st), 16'd1);
`endif
      idle(3);

      // lw $5 then add $6,$5,$5
      step("lw5", 0, 0, 0, 0, 5, 1, 1, 1, 0);
      cnt0 = stall_cnt;
      step("use5a", 5, 5, 1, 1, 6, 1, 0, 1, 0);
      check("ldu.stall",  16'(obs_st), 16'd1);
      check("ldu.bubble", 16'(obs_bb), 16'd1);
      step("use5b", 5, 5, 1, 1, 6, 1, 0, 1, 0);
`ifdef HAZARD_FORWARD_EN
      check("ldu.sel1", 16'(obs_m1), 16'd2);
      check("ldu.sel2", 16'(obs_m2), 16'd2);
      check("ldu.cnt_inc", stall_cnt - cnt0, 16'd1);
`endif
      idle(3);

      // WB and MEM both write $7, then only WB
      step("p7a", 0, 0, 0, 0, 7, 1, 0, 1, 0);
      step("p7b", 0, 0, 0, 0, 7, 1, 0, 1, 0);
      idle(1);
      step("c7young", 7, 0, 1, 0, 8, 1, 0, 1, 0);
`ifdef HAZARD_FORWARD_EN
      check("wb_young.sel", 16'(obs_m1), 16'd2);
`endif
      idle(3);
      step("p7c", 0, 0, 0, 0, 7, 1, 0, 1, 0);
      idle(2);
      step("c7wb", 0, 7, 0, 1, 8, 1, 0, 1, 0);
`ifdef HAZARD_FORWARD_EN
      check("wb_only.sel", 16'(obs_m2), 16'd3);
`endif
      idle(3);

      // register 0 never forwards or stalls
      step("p0", 0, 0, 0, 0, 0, 1, 1, 1, 0);
      step("c0", 0, 0, 1, 1, 9, 1, 0, 1, 0);
      check("r0.sel1",  16'(obs_m1), 16'd0);
      check("r0.stall", 16'(obs_st), 16'd0);
      idle(3);

      // flush during a load-use hazard; the flushed writer of $9 must not enter EX
      step("lw5f", 0, 0, 0, 0, 5, 1, 1, 1, 0);
      step("flush", 5, 0, 1, 0, 9, 1, 0, 1, 1);
      check("flush.stall",  16'(obs_st), 16'd0);
      check("flush.bubble", 16'(obs_bb), 16'd1);
      step("after_fl", 9, 0, 1, 0, 10, 1, 0, 1, 0);
      check("flush.ex_inv.sel",   16'(obs_m1), 16'd0);
      check("flush.ex_inv.stall", 16'(obs_st), 16'd0);
      idle(3);

      // add $3 then add $4,$3,$0 held until released
      step("add3b", 0, 0, 0, 0, 3, 1, 0, 1, 0);
      nst = 0;
      for (int i = 0; i < 8; i++) begin
         step("add4", 3, 0, 1, 1, 4, 1, 0, 1, 0);
         if (!obs_st) break;
         nst++;
      end
`ifdef HAZARD_FORWARD_EN
      check("nofwd.stalls", 16'(nst), 16'd0);
`else
      check("nofwd.stalls", 16'(nst), 16'd3);
`endif
      idle(3);

      // reset asserted mid-stall discards in-flight entries
      step("lw5r", 0, 0, 0, 0, 5, 1, 1, 1, 0);
      @(negedge clk);
      id_rs = 5; id_use_rs = 1; id_rt = 0; id_use_rt = 0;
      id_wr_addr = 6; id_regwrite = 1; id_load = 0; id_valid = 1; flush = 0;
      #1;
      check("midrst.pre_stall", 16'(stall), 16'd1);
      rst_n = 1'b0;
      #1;
      check("midrst.stall",  16'(stall),     16'd0);
      check("midrst.bubble", 16'(bubble),    16'd0);
      check("midrst.cnt",    stall_cnt,      16'd0);
      check("midrst.mux1",   16'(mux_ctrl1), 16'd0);
      $display("step midrst     rst asserted -> st=%0b bb=%0b cnt=%0d", stall, bubble, stall_cnt);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 5, 0, 1, 0, 6, 1, 0, 1, 0);
      check("post_rst.stall", 16'(obs_st), 16'd0);

      // random traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step("rand",
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
